// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues memory reads at iPC, captures the returned word
// into oIR and drives the PC block's increment/load/offset controls.
// Optional macro FETCH_SEQ_TIMEOUT_EN adds a WAIT-state timeout counter and a sticky FAULT state.
//
// state | meaning
// IDLE  | not fetching, waiting for iEn
// REQ   | read request issued at iPC
// WAIT  | waiting for iMemRdy
// HOLD  | oIR valid, waiting for iIRAck
// FAULT | memory timed out, held until iRst (macro builds only)
module fetch_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEn,
    input  logic [31:0] iPC,
    output logic [31:0] oMemAddr,
    output logic        oMemRd,
    input  logic        iMemRdy,
    input  logic [31:0] iMemData,
    output logic [31:0] oIR,
    output logic        oIRValid,
    input  logic        iIRAck,
    input  logic        iRedirect,
    input  logic        iRedirectAbs,
    input  logic [31:0] iRedirectVal,
    output logic        oPC_En,
    output logic        oPC_LoadEn,
    output logic        oPC_OffsetEn,
    output logic [31:0] oPC_Load,
    output logic [31:0] oPC_Offset,
    output logic        oBusy,
    output logic        oFault
);

`ifdef FETCH_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ir_q;
    logic        ir_valid_q;
    logic        ir_load;
    logic        ir_ack;
    logic        mem_rd;
    logic        pc_en;
    logic        pc_load_en;
    logic        pc_offset_en;
    logic [31:0] pc_load;
    logic [31:0] pc_offset;

`ifdef FETCH_SEQ_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             fault_q;
    logic             timed_out;

    assign timed_out = (wait_cnt == CNT_LAST);
`else
    logic timed_out;

    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        mem_rd       = 1'b0;
        ir_load      = 1'b0;
        ir_ack       = 1'b0;
        pc_en        = 1'b0;
        pc_load_en   = 1'b0;
        pc_offset_en = 1'b0;
        pc_load      = 32'd0;
        pc_offset    = 32'd0;
        case (state)
            IDLE: begin
                if (iEn) state_nxt = REQ;
            end
            REQ: begin
                mem_rd    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                mem_rd = 1'b1;
                if (iMemRdy) begin
                    ir_load   = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = HOLD;
                end else if (timed_out) begin
`ifdef FETCH_SEQ_TIMEOUT_EN
                    state_nxt = FAULT;
`endif
                end
            end
            HOLD: begin
                if (iIRAck) begin
                    ir_ack    = 1'b1;
                    state_nxt = iEn ? REQ : IDLE;
                    if (iRedirect) begin
                        pc_en = 1'b1;
                        if (iRedirectAbs) begin
                            pc_load_en = 1'b1;
                            pc_load    = iRedirectVal;
                        end else begin
                            pc_offset_en = 1'b1;
                            pc_offset    = iRedirectVal;
                        end
                    end
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= IDLE;
            ir_q       <= 32'd0;
            ir_valid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ir_load) begin
                ir_q       <= iMemData;
                ir_valid_q <= 1'b1;
            end else if (ir_ack) begin
                ir_valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_SEQ_TIMEOUT_EN
    // Counter restarts from zero on every REQ->WAIT transition.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (state == REQ)
                wait_cnt <= '0;
            else if (state == WAIT && !iMemRdy && !timed_out)
                wait_cnt <= wait_cnt + 1'b1;
            if (state_nxt == FAULT)
                fault_q <= 1'b1;
        end
    end

    assign oFault = fault_q;
`else
    assign oFault = 1'b0;
`endif

    // Reset gates every control output so nothing reaches memory or the PC on a reset edge.
    assign oMemAddr     = iPC;
    assign oMemRd       = mem_rd       & ~iRst;
    assign oBusy        = (state != IDLE) & ~iRst;
    assign oPC_En       = pc_en        & ~iRst;
    assign oPC_LoadEn   = pc_load_en   & ~iRst;
    assign oPC_OffsetEn = pc_offset_en & ~iRst;
    assign oPC_Load     = iRst ? 32'd0 : pc_load;
    assign oPC_Offset   = iRst ? 32'd0 : pc_offset;
    assign oIR          = ir_q;
    assign oIRValid     = ir_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus stall and timeout sequences.
module tb_fetch_sequencer;

    logic        iClk;
    logic        iRst;
    logic        iEn;
    logic [31:0] iPC;
    logic [31:0] oMemAddr;
    logic        oMemRd;
    logic        iMemRdy;
    logic [31:0] iMemData;
    logic [31:0] oIR;
    logic        oIRValid;
    logic        iIRAck;
    logic        iRedirect;
    logic        iRedirectAbs;
    logic [31:0] iRedirectVal;
    logic        oPC_En;
    logic        oPC_LoadEn;
    logic        oPC_OffsetEn;
    logic [31:0] oPC_Load;
    logic [31:0] oPC_Offset;
    logic        oBusy;
    logic        oFault;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iEn          (iEn),
        .iPC          (iPC),
        .oMemAddr     (oMemAddr),
        .oMemRd       (oMemRd),
        .iMemRdy      (iMemRdy),
        .iMemData     (iMemData),
        .oIR          (oIR),
        .oIRValid     (oIRValid),
        .iIRAck       (iIRAck),
        .iRedirect    (iRedirect),
        .iRedirectAbs (iRedirectAbs),
        .iRedirectVal (iRedirectVal),
        .oPC_En       (oPC_En),
        .oPC_LoadEn   (oPC_LoadEn),
        .oPC_OffsetEn (oPC_OffsetEn),
        .oPC_Load     (oPC_Load),
        .oPC_Offset   (oPC_Offset),
        .oBusy        (oBusy),
        .oFault       (oFault)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // flags = {memrd, busy, irvalid, pc_en, load_en, offset_en, fault}
    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] pc;
        logic        rdy;
        logic [31:0] data;
        logic        ack;
        logic        redir;
        logic        abs_mode;
        logic [31:0] val;
        logic [6:0]  flags;
        logic [31:0] ir;
        logic [31:0] load;
        logic [31:0] offset;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic [31:0] pc,
                       input logic rdy, input logic [31:0] data,
                       input logic ack, input logic redir, input logic abs_mode,
                       input logic [31:0] val, input logic [6:0] flags,
                       input logic [31:0] ir, input logic [31:0] load,
                       input logic [31:0] offset);
        vec_t v;
        v.rst = rst; v.en = en; v.pc = pc; v.rdy = rdy; v.data = data;
        v.ack = ack; v.redir = redir; v.abs_mode = abs_mode; v.val = val;
        v.flags = flags; v.ir = ir; v.load = load; v.offset = offset;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic rdy,
                         input logic [31:0] data, input logic ack);
        iRst = rst; iEn = en; iMemRdy = rdy; iMemData = data;
        iIRAck = ack; iRedirect = 1'b0; iRedirectAbs = 1'b0; iRedirectVal = 32'd0;
    endtask

    logic [134:0] act_w;
    logic [134:0] exp_w;
    int mr_cnt;
    int pe_cnt;
    int ir_bad;

    initial begin
        iPC = 32'h100;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge iClk);

        //  rst en  pc            rdy data           ack rd  abs val            flags       ir             load      offset
        add(1, 0, 32'h100,  0, 32'h0,        0, 0, 0, 32'h0,        7'b0000000, 32'h0,        32'h0,    32'h0);
        add(0, 1, 32'h100,  0, 32'h0,        0, 0, 0, 32'h0,        7'b0000000, 32'h0,        32'h0,    32'h0);
        add(0, 1, 32'h100,  0, 32'h0,        0, 0, 0, 32'h0,        7'b1100000, 32'h0,        32'h0,    32'h0);
        add(0, 1, 32'h100,  1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        7'b1101000, 32'h0,        32'h0,    32'h0);
        add(0, 1, 32'h104,  0, 32'h0,        1, 0, 0, 32'h0,        7'b0110000, 32'hDEADBEEF, 32'h0,    32'h0);
        add(0, 1, 32'h104,  0, 32'h0,        0, 0, 0, 32'h0,        7'b1100000, 32'hDEADBEEF, 32'h0,    32'h0);
        add(0, 1, 32'h104,  1, 32'h11112222, 0, 0, 0, 32'h0,        7'b1101000, 32'hDEADBEEF, 32'h0,    32'h0);
        add(0, 1, 32'h108,  0, 32'h0,        1, 1, 1, 32'h2000,     7'b0111100, 32'h11112222, 32'h2000, 32'h0);
        add(0, 1, 32'h2000, 0, 32'h0,        1, 1, 1, 32'h9999,     7'b1100000, 32'h11112222, 32'h0,    32'h0);
        add(0, 1, 32'h2000, 1, 32'h33334444, 0, 0, 0, 32'h0,        7'b1101000, 32'h11112222, 32'h0,    32'h0);
        add(0, 1, 32'h2004, 0, 32'h0,        0, 1, 1, 32'h5555,     7'b0110000, 32'h33334444, 32'h0,    32'h0);
        add(0, 1, 32'h2004, 0, 32'h0,        1, 1, 0, 32'hFFFFFFF8, 7'b0111010, 32'h33334444, 32'h0,    32'hFFFFFFF8);
        add(0, 0, 32'h1FFC, 0, 32'h0,        0, 0, 0, 32'h0,        7'b1100000, 32'h33334444, 32'h0,    32'h0);
        add(0, 0, 32'h1FFC, 0, 32'h0,        0, 0, 0, 32'h0,        7'b1100000, 32'h33334444, 32'h0,    32'h0);
        add(0, 0, 32'h1FFC, 1, 32'hCAFEF00D, 0, 0, 0, 32'h0,        7'b1101000, 32'h33334444, 32'h0,    32'h0);
        add(0, 0, 32'h2000, 0, 32'h0,        1, 0, 0, 32'h0,        7'b0110000, 32'hCAFEF00D, 32'h0,    32'h0);
        add(0, 0, 32'h2000, 0, 32'h0,        0, 0, 0, 32'h0,        7'b0000000, 32'hCAFEF00D, 32'h0,    32'h0);
        add(0, 1, 32'h2000, 0, 32'h0,        0, 0, 0, 32'h0,        7'b0000000, 32'hCAFEF00D, 32'h0,    32'h0);
        add(0, 1, 32'h2000, 0, 32'h0,        0, 0, 0, 32'h0,        7'b1100000, 32'hCAFEF00D, 32'h0,    32'h0);
        add(0, 1, 32'h2000, 0, 32'h0,        0, 0, 0, 32'h0,        7'b1100000, 32'hCAFEF00D, 32'h0,    32'h0);
        add(1, 1, 32'h2000, 1, 32'h77,       0, 0, 0, 32'h0,        7'b0000000, 32'hCAFEF00D, 32'h0,    32'h0);
        add(0, 0, 32'h2000, 0, 32'h0,        0, 0, 0, 32'h0,        7'b0000000, 32'h0,        32'h0,    32'h0);
        add(0, 1, 32'h300,  0, 32'h0,        0, 0, 0, 32'h0,        7'b0000000, 32'h0,        32'h0,    32'h0);
        add(0, 1, 32'h300,  0, 32'h0,        0, 0, 0, 32'h0,        7'b1100000, 32'h0,        32'h0,    32'h0);
        add(0, 1, 32'h300,  1, 32'hABCD0123, 0, 0, 0, 32'h0,        7'b1101000, 32'h0,        32'h0,    32'h0);
        add(1, 1, 32'h304,  0, 32'h0,        1, 1, 1, 32'h40,       7'b0010000, 32'hABCD0123, 32'h0,    32'h0);
        add(0, 0, 32'h304,  0, 32'h0,        0, 0, 0, 32'h0,        7'b0000000, 32'h0,        32'h0,    32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge iClk);
            iRst = vecs[i].rst; iEn = vecs[i].en; iPC = vecs[i].pc;
            iMemRdy = vecs[i].rdy; iMemData = vecs[i].data; iIRAck = vecs[i].ack;
            iRedirect = vecs[i].redir; iRedirectAbs = vecs[i].abs_mode;
            iRedirectVal = vecs[i].val;
            #1;
            act_w = {oMemRd, oBusy, oIRValid, oPC_En, oPC_LoadEn, oPC_OffsetEn, oFault,
                     oIR, oPC_Load, oPC_Offset, oMemAddr};
            exp_w = {vecs[i].flags, vecs[i].ir, vecs[i].load, vecs[i].offset, vecs[i].pc};
            checks++;
            if (act_w !== exp_w) begin
                failures++;
                $display("FAIL vec%0d: got %h expected %h", i, act_w, exp_w);
            end
        end

        // Stalled fetch: memory ready in the 5th WAIT cycle, ack in the 4th HOLD cycle.
        mr_cnt = 0; pe_cnt = 0; ir_bad = 0;
        iPC = 32'h400;
        for (int c = 0; c < 12; c++) begin
            @(negedge iClk);
            drive(1'b0, c == 0, c == 6, (c == 6) ? 32'h5A5A1234 : 32'h00000BAD, c == 10);
            #1;
            if (oMemRd) mr_cnt++;
            if (oPC_En) pe_cnt++;
            if (c >= 7 && c <= 10 && (oIR !== 32'h5A5A1234 || oIRValid !== 1'b1)) ir_bad++;
            if (c == 11) chk("stall_idle_busy", {31'd0, oBusy}, 32'd0);
        end
        chk("stall_memrd_cycles", mr_cnt, 32'd6);
        chk("stall_pc_pulses", pe_cnt, 32'd1);
        chk("stall_ir_unstable", ir_bad, 32'd0);

        // Memory never responds.
        @(negedge iClk);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge iClk);
            drive(1'b0, c == 0, 1'b0, 32'd0, 1'b0);
            #1;
`ifdef FETCH_SEQ_TIMEOUT_EN
            chk($sformatf("timeout_fault_c%0d", c), {31'd0, oFault}, {31'd0, c >= 6});
            chk($sformatf("timeout_memrd_c%0d", c), {31'd0, oMemRd}, {31'd0, (c >= 1 && c <= 5)});
`else
            chk($sformatf("nofault_c%0d", c), {31'd0, oFault}, 32'd0);
            chk($sformatf("wait_memrd_c%0d", c), {31'd0, oMemRd}, {31'd0, c >= 1});
`endif
        end
        @(negedge iClk);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge iClk);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        chk("post_reset_fault", {31'd0, oFault}, 32'd0);
        chk("post_reset_busy", {31'd0, oBusy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have exactly one parameter: TIMEOUT_CYCLES, default 255, the WAIT-state cycle limit before fault; it is used only when FETCH_SEQ_TIMEOUT_EN is defined.
REQ-002 iClk  input  1  sole clock; all state updates on the rising edge.
REQ-003 iRst  input  1  reset, synchronous, active-high.
REQ-004 iEn  input  1  run enable; fetching starts or continues while high.
REQ-005 iPC  input  32  current program-counter value from the PC block.
REQ-006 oMemAddr  output  32  instruction address, equal to iPC, combinational.
REQ-007 oMemRd  output  1  memory read request.
REQ-008 iMemRdy  input  1  memory read complete; iMemData is valid in the same cycle.
REQ-009 iMemData  input  32  fetched instruction word.
REQ-010 oIR  output  32  registered instruction.
REQ-011 oIRValid  output  1  oIR is valid and awaiting consumption.
REQ-012 iIRAck  input  1  consumer accepts oIR.
REQ-013 iRedirect  input  1  redirect the PC, sampled only with an accepted iIRAck.
REQ-014 iRedirectAbs  input  1  redirect mode: 1 = absolute load, 0 = relative offset.
REQ-015 iRedirectVal  input  32  target address or signed offset.
REQ-016 oPC_En, oPC_LoadEn, oPC_OffsetEn  output  1 each  PC block controls.
REQ-017 oPC_Load, oPC_Offset  output  32 each  PC block operands.
REQ-018 oBusy  output  1  high whenever the state is not IDLE.
REQ-019 oFault  output  1  sticky memory-timeout flag.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and FAULT; FAULT exists only with the macro defined.
REQ-021 IDLE: when iEn is high, the next state SHALL be REQ; otherwise the FSM stays in IDLE.
REQ-022 REQ and WAIT SHALL drive oMemRd = 1; REQ SHALL always advance to WAIT.
REQ-023 WAIT with iMemRdy = 1 SHALL, on the same edge: load iMemData into oIR, set oIRValid, enter HOLD, and pulse oPC_En = 1 with oPC_LoadEn = oPC_OffsetEn = 0 (sequential increment).
REQ-024 oPC_En, oPC_LoadEn, oPC_OffsetEn, oPC_Load and oPC_Offset SHALL be decoded combinationally from state and inputs, so the PC updates on the same edge as the state transition.
REQ-025 HOLD SHALL keep oIR and oIRValid stable until iIRAck is high; ack in any other state SHALL be ignored.
REQ-026 HOLD with iIRAck = 1 and iRedirect = 1 SHALL pulse oPC_En = 1 for one cycle with:
  - iRedirectAbs = 1: oPC_LoadEn = 1, oPC_Load = iRedirectVal;
  - iRedirectAbs = 0: oPC_OffsetEn = 1, oPC_Offset = iRedirectVal, applied to the already-incremented PC.
REQ-027 HOLD with iIRAck = 1: oIRValid SHALL clear, and the next state SHALL be REQ if iEn = 1, else IDLE.
REQ-028 In every cycle other than those in REQ-023 and REQ-026, oPC_En, oPC_LoadEn and oPC_OffsetEn SHALL be 0.
REQ-029 oPC_Load and oPC_Offset SHALL be 0 whenever their respective enable is 0.
REQ-030 When iEn falls mid-fetch, the current fetch SHALL complete through HOLD, then the FSM enters IDLE.
REQ-031 iRedirect SHALL be ignored when iIRAck is 0.
REQ-032 Back-to-back fetch latency SHALL be 3 cycles (REQ, WAIT, HOLD) when memory is ready immediately and ack is immediate.

Reset
REQ-033 While iRst is high at a clock edge, the block SHALL enter IDLE with oIR = 0, oIRValid = 0, oFault = 0 and the timeout counter = 0.
REQ-034 During reset, oMemRd, oBusy and all oPC_* outputs SHALL be 0.
REQ-035 Reset during WAIT or HOLD SHALL abandon the fetch with no PC update on the reset edge.

Configuration
REQ-036 With FETCH_SEQ_TIMEOUT_EN defined:
  - an 8-to-32-bit counter SHALL count WAIT cycles and clear on entering WAIT;
  - reaching TIMEOUT_CYCLES without iMemRdy SHALL enter FAULT;
  - in FAULT, oFault = 1, oMemRd = 0, no PC pulses, and the FSM stays in FAULT until iRst.
REQ-037 Without FETCH_SEQ_TIMEOUT_EN, the block SHALL have no counter and no FAULT state, WAIT SHALL wait indefinitely, and oFault SHALL be tied to 0.

Verification
REQ-038 Basic fetch: iPC = 0x100, iEn = 1, iMemRdy high in the first WAIT cycle, iMemData = 0xDEADBEEF, ack at once -> oMemAddr = 0x100, oIR = 0xDEADBEEF, one increment pulse, next REQ 3 cycles after the first.
REQ-039 Absolute redirect: in HOLD, ack with iRedirect = 1, iRedirectAbs = 1, iRedirectVal = 0x2000 -> one pulse with oPC_LoadEn = 1, oPC_Load = 0x2000, then REQ.
REQ-040 Relative redirect: ack with iRedirectAbs = 0, iRedirectVal = 0xFFFFFFF8 -> one pulse with oPC_OffsetEn = 1, oPC_Offset = 0xFFFFFFF8.
REQ-041 Stalls: iMemRdy delayed 5 cycles, ack delayed 4 -> oMemRd high for 6 cycles, oIR stable through HOLD, exactly one increment.
REQ-042 Reset in WAIT: iRst = 1 in WAIT -> next cycle IDLE, oMemRd = 0, no oPC_En pulse.
REQ-043 Timeout (macro defined, TIMEOUT_CYCLES = 4): iMemRdy held low -> oFault = 1 after 4 WAIT cycles and stays high until iRst.
